mini_src_datapath: RTL and testbench
====================================

Name: mini_src_datapath

Overview:
- 32-bit Mini-SRC processor datapath, driven cycle by cycle by an external control unit (or bench) through one-hot control strobes.
- Contains a single 32-bit bus, R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, an ALU, and select-and-encode logic for IR register fields.
- Memory is external: data enters on Mdatain; address and write data leave via MAR/MDR outputs.

Parameters:
- WIDTH, 32, datapath/register width; Z is 2*WIDTH.

Ports:
- Clock  in  1  system clock; all registers update on the rising edge.
- Clear  in  1  synchronous active-high reset; clears every register.
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout  in  1 each  bus-source strobes.
- Rout, BAout  in  1 each  GP-register bus-source strobes.
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin  in  1 each  register load enables.
- Gra, Grb, Grc  in  1 each  select the Ra, Rb or Rc field of IR.
- Read  in  1  MDR input mux: 1 selects Mdatain, 0 selects bus.
- Write  in  1  memory write request; passed through to mem_we.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC  in  1 each  ALU operation strobes.
- Mdatain  in  32  memory read data.
- mem_addr  out  32  current MAR value.
- mem_wdata  out  32  current MDR value.
- mem_we  out  1  equals Write, combinational.
- BusMuxOut  out  32  current bus value, for debug.

Behaviour:
- Reset: Clear=1 at a rising edge zeroes R0–R15, PC, IR, MAR, MDR, Y, Z, HI and LO. Clear overrides every load enable in that cycle. Outputs follow the registers, so after reset mem_addr=0, mem_wdata=0, BusMuxOut=0 with no strobes.
- IR fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- C_sign_extended = sign-extension of IR[18:0] to 32 bits.
- Select/encode:
  - idx = (Gra?Ra:0) | (Grb?Rb:0) | (Grc?Rc:0).
  - Decode idx one-hot.
  - Rin loads R[idx] from the bus.
  - Rout or BAout places R[idx] on the bus.
  - When BAout=1 and idx=0, the bus carries 0, not R0.
- Bus mux is combinational. Source priority:
  - PC > Zlow > Zhigh > MDR > HI > LO > C_sign_extended (Cout) > R[idx].
  - No source asserted → bus = 0.
  - Control guarantees one-hot; the priority only defines the result otherwise.
- Register loads, each on the rising edge when its enable is high:
  - Y ← bus; PC ← bus; IR ← bus; MAR ← bus; HI ← bus; LO ← bus.
  - MDR ← (Read ? Mdatain : bus) when MDRin=1.
  - Z (64-bit) ← ALU result when Zin=1.
- ALU operands: A=Y, B=bus. Z result by op:
  - ADD: A+B. SUB: A−B. AND, OR: bitwise. High word 0 for these.
  - NEG: −B. NOT: ~B.
  - SHR: logical right. SHRA: arithmetic right. SHL: left. ROR, ROL: rotates. A is shifted by B[4:0].
  - MUL: signed 64-bit product.
  - DIV: signed quotient in Zlow, remainder in Zhigh. Divide by zero gives quotient 0, remainder A.
  - IncPC: B+1.
  - No op strobe: 0.
- Op priority if several are asserted: IncPC > ADD > SUB > AND > OR > SHR > SHRA > SHL > ROR > ROL > MUL > DIV > NEG > NOT.
- Overflow is ignored; 32-bit arithmetic wraps mod 2^32.
- Latency: every register transfer takes 1 clock. Sequences such as fetch (T0–T2) and ld (T3–T7) are entirely control-driven.
- R0 is a real register. The zero-source behaviour applies only through BAout.

Test Plan:
- Reset: preload registers, then Clear=1 for one edge → all registers read 0 and BusMuxOut=0.
- Fetch with PC=0:
  - T0 PCout, MARin, IncPC, Zin → MAR=0, Z=1.
  - T1 Zlowout, PCin, Read, MDRin with Mdatain=0x00800054 → PC=1, MDR=0x00800054.
  - T2 MDRout, IRin → IR=0x00800054.
- ld R1,0x54(R0), continuing from the fetch:
  - T3 Grb, BAout, Yin → Y=0 despite R0=0xFFFFFFFF.
  - T4 Cout, ADD, Zin → Z=0x54.
  - T5 Zlowout, MARin → mem_addr=0x54.
  - T6 Read, MDRin with Mdatain=0x12345678.
  - T7 MDRout, Gra, Rin → R1=0x12345678.
- Negative sign extension: IR[18:0]=0x7FFFF with Cout → bus=0xFFFFFFFF.
- Multiply and divide:
  - Y=0xFFFFFFFE, bus=3, MUL → Z=0xFFFFFFFF_FFFFFFFA.
  - Y=17, bus=5, DIV → Zlow=3, Zhigh=2.
  - bus=0, DIV → Zlow=0, Zhigh=17.
- Shifts and rotates with Y=0x80000001, bus=1:
  - SHRA → 0xC0000000.
  - SHR → 0x40000000.
  - ROL → 0x00000003.
  - ROR → 0xC0000000.
  - SHL → 0x00000002.

Source files
------------

// File: rtl/mini_src_datapath.sv
// mini_src_datapath: 32-bit Mini-SRC processor datapath. The datapath has no
// sequencing of its own. An external control unit drives one-hot strobes every
// cycle, and each register transfer completes on the next rising edge.
//
// Ports
//   Clock, Clear        : clock, synchronous active-high clear of all registers
//   PCout..Cout, Rout,
//   BAout               : bus-source strobes (PC, Zlow, Zhigh, MDR, HI, LO,
//                         sign-extended IR constant, selected GP register)
//   PCin..Rin           : register load enables (Rin loads the selected GP reg)
//   Gra, Grb, Grc       : choose the Ra/Rb/Rc field of IR as GP register index
//   Read                : MDR source select, 1 = Mdatain, 0 = bus
//   Write               : memory write request, passed to mem_we
//   AND..NOT, IncPC     : ALU operation strobes (Y op bus -> Z)
//   Mdatain             : memory read data
//   mem_addr, mem_wdata : MAR and MDR contents
//   mem_we              : equals Write
//   BusMuxOut           : current bus value
module mini_src_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             Zhighout,
  input  logic             MDRout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Cout,
  input  logic             Rout,
  input  logic             BAout,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Rin,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Read,
  input  logic             Write,
  input  logic             AND,
  input  logic             OR,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             MUL,
  input  logic             DIV,
  input  logic             SHR,
  input  logic             SHRA,
  input  logic             SHL,
  input  logic             ROR,
  input  logic             ROL,
  input  logic             NEG,
  input  logic             NOT,
  input  logic             IncPC,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] BusMuxOut
);

  logic [WIDTH-1:0]   r_gpr [16];
  logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_z;

  logic [WIDTH-1:0]   w_bus;
  logic [WIDTH-1:0]   w_csext;
  logic [3:0]         w_idx;
  logic [15:0]        w_rsel;
  logic [2*WIDTH-1:0] w_alu;
  logic [2*WIDTH-1:0] w_mul;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [4:0]         w_sh;
  logic               w_unused_ir;

  // Opcode bits of IR are decoded by the control unit, not here.
  assign w_unused_ir = ^r_ir[WIDTH-1:27];

  // Select-and-encode: OR of the gated IR fields, then one-hot decode.
  assign w_idx  = (Gra ? r_ir[26:23] : 4'd0) |
                  (Grb ? r_ir[22:19] : 4'd0) |
                  (Grc ? r_ir[18:15] : 4'd0);
  assign w_rsel = 16'd1 << w_idx;

  assign w_csext = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};

  // Bus mux, fixed priority; control normally asserts only one source.
  always_comb begin
    w_bus = '0;
    if (PCout)              w_bus = r_pc;
    else if (Zlowout)       w_bus = r_z[WIDTH-1:0];
    else if (Zhighout)      w_bus = r_z[2*WIDTH-1:WIDTH];
    else if (MDRout)        w_bus = r_mdr;
    else if (HIout)         w_bus = r_hi;
    else if (LOout)         w_bus = r_lo;
    else if (Cout)          w_bus = w_csext;
    else if (Rout || BAout) begin
      // Base-address reads of index 0 yield zero so "0(R0)" means absolute.
      if (BAout && (w_idx == 4'd0)) w_bus = '0;
      else                          w_bus = r_gpr[w_idx];
    end
  end

  // ALU: A is Y, B is the bus.
  assign w_sh  = w_bus[4:0];
  assign w_mul = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y}) *
                 $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});

  always_comb begin
    if (w_bus == '0) begin
      w_quo = '0;
      w_rem = r_y;
    end else begin
      w_quo = $signed(r_y) / $signed(w_bus);
      w_rem = $signed(r_y) % $signed(w_bus);
    end
  end

  always_comb begin
    w_alu = '0;
    if (IncPC)     w_alu = {{WIDTH{1'b0}}, w_bus + 1'b1};
    else if (ADD)  w_alu = {{WIDTH{1'b0}}, r_y + w_bus};
    else if (SUB)  w_alu = {{WIDTH{1'b0}}, r_y - w_bus};
    else if (AND)  w_alu = {{WIDTH{1'b0}}, r_y & w_bus};
    else if (OR)   w_alu = {{WIDTH{1'b0}}, r_y | w_bus};
    else if (SHR)  w_alu = {{WIDTH{1'b0}}, r_y >> w_sh};
    else if (SHRA) w_alu = {{WIDTH{1'b0}}, WIDTH'($signed(r_y) >>> w_sh)};
    else if (SHL)  w_alu = {{WIDTH{1'b0}}, r_y << w_sh};
    // A shift by 32 (amount 0) contributes nothing, so rotate-by-0 is A.
    else if (ROR)  w_alu = {{WIDTH{1'b0}},
                            (r_y >> w_sh) | (r_y << (6'd32 - {1'b0, w_sh}))};
    else if (ROL)  w_alu = {{WIDTH{1'b0}},
                            (r_y << w_sh) | (r_y >> (6'd32 - {1'b0, w_sh}))};
    else if (MUL)  w_alu = w_mul;
    else if (DIV)  w_alu = {w_rem, w_quo};
    else if (NEG)  w_alu = {{WIDTH{1'b0}}, -w_bus};
    else if (NOT)  w_alu = {{WIDTH{1'b0}}, ~w_bus};
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_z   <= '0;
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
    end else begin
      if (PCin)  r_pc  <= w_bus;
      if (IRin)  r_ir  <= w_bus;
      if (MARin) r_mar <= w_bus;
      if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
      if (Yin)   r_y   <= w_bus;
      if (HIin)  r_hi  <= w_bus;
      if (LOin)  r_lo  <= w_bus;
      if (Zin)   r_z   <= w_alu;
      for (int i = 0; i < 16; i++) begin
        if (Rin && w_rsel[i]) r_gpr[i] <= w_bus;
      end
    end
  end

  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;
  assign mem_we    = Write;
  assign BusMuxOut = w_bus;

endmodule

// File: tb/tb_mini_src_datapath.sv
module tb_mini_src_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, Rout, BAout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin;
  logic        Gra, Grb, Grc, Read, Write;
  logic [13:0] ops;
  logic [31:0] Mdatain;
  logic [31:0] mem_addr, mem_wdata, BusMuxOut;
  logic        mem_we;

  // ops bit positions
  localparam int OP_INC = 0,  OP_ADD = 1,  OP_SUB = 2,  OP_AND = 3,  OP_OR = 4;
  localparam int OP_SHR = 5,  OP_SHRA = 6, OP_SHL = 7,  OP_ROR = 8,  OP_ROL = 9;
  localparam int OP_MUL = 10, OP_DIV = 11, OP_NEG = 12, OP_NOT = 13;
  // peek sources
  localparam int S_PC = 0, S_ZLO = 1, S_ZHI = 2, S_MDR = 3, S_HI = 4, S_LO = 5;
  localparam int S_C = 6, S_R = 7, S_BA = 8, S_NONE = 9;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mini_src_datapath #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .AND(ops[OP_AND]), .OR(ops[OP_OR]), .ADD(ops[OP_ADD]), .SUB(ops[OP_SUB]),
    .MUL(ops[OP_MUL]), .DIV(ops[OP_DIV]), .SHR(ops[OP_SHR]),
    .SHRA(ops[OP_SHRA]), .SHL(ops[OP_SHL]), .ROR(ops[OP_ROR]),
    .ROL(ops[OP_ROL]), .NEG(ops[OP_NEG]), .NOT(ops[OP_NOT]),
    .IncPC(ops[OP_INC]),
    .Mdatain(Mdatain), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .BusMuxOut(BusMuxOut)
  );

  // clock / watchdog
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic look(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got=%h expected=<queue empty>", tag, got);
    end else begin
      chk(tag, got, exp_q.pop_front());
    end
  endtask

  // drivers
  task automatic clr_ctl();
    {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, Rout, BAout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin} = '0;
    {Gra, Grb, Grc, Read, Write} = '0;
    ops = '0;
  endtask

  // Hold the current controls through one rising edge, then drop them.
  task automatic cyc();
    @(posedge Clock);
    #1;
    clr_ctl();
  endtask

  // Drive one bus source (Gr* set by caller), compare bus against queue head.
  task automatic peek(input int src, input string tag);
    case (src)
      S_PC:  PCout    = 1'b1;
      S_ZLO: Zlowout  = 1'b1;
      S_ZHI: Zhighout = 1'b1;
      S_MDR: MDRout   = 1'b1;
      S_HI:  HIout    = 1'b1;
      S_LO:  LOout    = 1'b1;
      S_C:   Cout     = 1'b1;
      S_R:   Rout     = 1'b1;
      S_BA:  BAout    = 1'b1;
      default: ;
    endcase
    #1;
    look(tag, BusMuxOut);
    clr_ctl();
  endtask

  task automatic mem_load(input logic [31:0] v);
    Mdatain = v;
    Read    = 1'b1;
    MDRin   = 1'b1;
    cyc();
  endtask

  task automatic set_y(input logic [31:0] v);
    mem_load(v);
    MDRout = 1'b1;
    Yin    = 1'b1;
    cyc();
  endtask

  task automatic alu_run(input string tag, input logic [13:0] mask,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    set_y(a);
    mem_load(b);
    MDRout = 1'b1;
    ops    = mask;
    Zin    = 1'b1;
    cyc();
    push_exp(exp[31:0]);
    peek(S_ZLO, {tag, "_lo"});
    push_exp(exp[63:32]);
    peek(S_ZHI, {tag, "_hi"});
  endtask

  // Reference for the randomised ops.
  function automatic logic [63:0] model(input int op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SHL:  r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return {32'h0, r};
  endfunction

  localparam logic [31:0] PRE = 32'hA5A5_A5A5;

  initial begin
    clr_ctl();
    Mdatain = '0;
    Clear   = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Clear = 1'b0;

    // reset state, preload, clear with load enables active
    push_exp(32'h0); peek(S_PC, "init_pc");
    mem_load(PRE);
    MDRout = 1'b1; PCin = 1'b1; MARin = 1'b1; Yin = 1'b1; HIin = 1'b1;
    LOin = 1'b1; IRin = 1'b1; Rin = 1'b1; Zin = 1'b1; ops[OP_ADD] = 1'b1;
    cyc();
    push_exp(PRE); peek(S_PC, "pre_pc");
    push_exp(PRE); peek(S_ZLO, "pre_zlo");
    push_exp(PRE); peek(S_R, "pre_r0");
    push_exp(PRE); look("pre_mar", mem_addr);
    Clear = 1'b1; MDRout = 1'b1; PCin = 1'b1; Rin = 1'b1;
    cyc();
    Clear = 1'b0;
    push_exp(32'h0); peek(S_PC,  "clr_pc");
    push_exp(32'h0); peek(S_ZLO, "clr_zlo");
    push_exp(32'h0); peek(S_ZHI, "clr_zhi");
    push_exp(32'h0); peek(S_MDR, "clr_mdr");
    push_exp(32'h0); peek(S_HI,  "clr_hi");
    push_exp(32'h0); peek(S_LO,  "clr_lo");
    push_exp(32'h0); peek(S_C,   "clr_ir");
    push_exp(32'h0); peek(S_R,   "clr_r0");
    push_exp(32'h0); peek(S_NONE, "clr_bus");
    push_exp(32'h0); look("clr_mar", mem_addr);
    push_exp(32'h0); look("clr_mdr_out", mem_wdata);
    ops[OP_ADD] = 1'b1; Zin = 1'b1;   // Y + 0 exposes Y
    cyc();
    push_exp(32'h0); peek(S_ZLO, "clr_y");

    // R0 = all ones, then fetch from PC=0
    mem_load(32'hFFFF_FFFF);
    MDRout = 1'b1; Rin = 1'b1;
    cyc();
    PCout = 1'b1; MARin = 1'b1; ops[OP_INC] = 1'b1; Zin = 1'b1;
    #1; push_exp(32'h0); look("t0_bus", BusMuxOut);
    cyc();
    push_exp(32'h0); look("t0_mar", mem_addr);
    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h0080_0054;
    #1; push_exp(32'h1); look("t1_bus", BusMuxOut);
    cyc();
    push_exp(32'h0080_0054); look("t1_mdr", mem_wdata);
    MDRout = 1'b1; IRin = 1'b1;
    cyc();
    push_exp(32'h1); peek(S_PC, "t1_pc");
    push_exp(32'h54); peek(S_C, "t2_c");

    // ld R1,0x54(R0)
    Grb = 1'b1; push_exp(32'hFFFF_FFFF); peek(S_R, "r0_real");
    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
    #1; push_exp(32'h0); look("t3_ba0", BusMuxOut);
    cyc();
    Cout = 1'b1; ops[OP_ADD] = 1'b1; Zin = 1'b1;
    #1; push_exp(32'h54); look("t4_bus", BusMuxOut);
    cyc();
    Zlowout = 1'b1; MARin = 1'b1;
    cyc();
    push_exp(32'h54); look("t5_mar", mem_addr);
    Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h1234_5678;
    cyc();
    push_exp(32'h1234_5678); look("t6_mdr", mem_wdata);
    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    cyc();
    Gra = 1'b1; push_exp(32'h1234_5678); peek(S_R, "t7_r1");
    Write = 1'b1;
    #1; push_exp(32'h1); look("mem_we", {31'h0, mem_we});
    clr_ctl();

    // negative constant
    mem_load(32'h0007_FFFF);
    MDRout = 1'b1; IRin = 1'b1;
    cyc();
    push_exp(32'hFFFF_FFFF); peek(S_C, "c_neg");

    // ALU directed cases
    alu_run("mul",    14'd1 << OP_MUL,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    alu_run("div",    14'd1 << OP_DIV,  32'd17, 32'd5, {32'd2, 32'd3});
    alu_run("div0",   14'd1 << OP_DIV,  32'd17, 32'd0, {32'd17, 32'd0});
    alu_run("divneg", 14'd1 << OP_DIV,  32'hFFFF_FFEF, 32'd5, {32'hFFFF_FFFE, 32'hFFFF_FFFD});
    alu_run("shra",   14'd1 << OP_SHRA, 32'h8000_0001, 32'd1, {32'h0, 32'hC000_0000});
    alu_run("shr",    14'd1 << OP_SHR,  32'h8000_0001, 32'd1, {32'h0, 32'h4000_0000});
    alu_run("rol",    14'd1 << OP_ROL,  32'h8000_0001, 32'd1, {32'h0, 32'h0000_0003});
    alu_run("ror",    14'd1 << OP_ROR,  32'h8000_0001, 32'd1, {32'h0, 32'hC000_0000});
    alu_run("shl",    14'd1 << OP_SHL,  32'h8000_0001, 32'd1, {32'h0, 32'h0000_0002});
    alu_run("ror0",   14'd1 << OP_ROR,  32'h8000_0001, 32'd0, {32'h0, 32'h8000_0001});
    alu_run("neg",    14'd1 << OP_NEG,  32'd9, 32'd5, {32'h0, 32'hFFFF_FFFB});
    alu_run("not",    14'd1 << OP_NOT,  32'd9, 32'h0F0F_0000, {32'h0, 32'hF0F0_FFFF});
    alu_run("sub",    14'd1 << OP_SUB,  32'd3, 32'd5, {32'h0, 32'hFFFF_FFFE});
    alu_run("incpc",  14'd1 << OP_INC,  32'd100, 32'd7, {32'h0, 32'd8});
    alu_run("pri_add", (14'd1 << OP_ADD) | (14'd1 << OP_SUB), 32'd10, 32'd3, {32'h0, 32'd13});
    alu_run("pri_mul", (14'd1 << OP_MUL) | (14'd1 << OP_DIV), 32'd6, 32'd7, {32'h0, 32'd42});

    // randomised simple ops against the bench model
    for (int i = 0; i < 8; i++) begin
      int op;
      logic [31:0] a, b;
      case ($urandom_range(0, 4))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_AND;
        3: op = OP_OR;
        default: op = OP_SHL;
      endcase
      a = $urandom;
      b = $urandom;
      alu_run($sformatf("rnd%0d_op%0d", i, op), 14'd1 << op, a, b, model(op, a, b));
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got=%0d expected=0 queued entries", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
